// File: rtl/gelato_warp_fetch_unit.sv
// Per-warp fetch unit: freezes a selected split entry, fetches its instruction, hands it to decode, releases the entry.
// Optional performance counters are enabled with `define GELATO_FETCH_PERF_EN.
`timescale 1ns/1ps

module gelato_warp_fetch_unit #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned INST_WIDTH      = 32,
    parameter int unsigned SPLIT_NUM_WIDTH = 2,
    parameter int unsigned THREAD_NUM      = 32,
    parameter int unsigned PC_STEP         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       sel_valid,
    input  logic [ADDR_WIDTH-1:0]      sel_pc,
    input  logic [SPLIT_NUM_WIDTH-1:0] sel_split_num,
    output logic                       upd_valid,
    output logic [SPLIT_NUM_WIDTH-1:0] upd_split_num,
    output logic [ADDR_WIDTH-1:0]      upd_pc,
    output logic                       upd_stall,
    input  logic [THREAD_NUM-1:0]      upd_thread_mask,
    output logic                       ic_req_valid,
    input  logic                       ic_req_ready,
    output logic [ADDR_WIDTH-1:0]      ic_req_addr,
    input  logic                       ic_rsp_valid,
    input  logic [INST_WIDTH-1:0]      ic_rsp_inst,
`ifdef GELATO_FETCH_PERF_EN
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_wait_cnt,
`endif
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [INST_WIDTH-1:0]      dec_inst,
    output logic [ADDR_WIDTH-1:0]      dec_pc,
    output logic [SPLIT_NUM_WIDTH-1:0] dec_split_num,
    output logic [THREAD_NUM-1:0]      dec_thread_mask
);

    localparam int unsigned PERF_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_COOL = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      pc_q, pc_d;
    logic [SPLIT_NUM_WIDTH-1:0] num_q, num_d;
    logic [THREAD_NUM-1:0]      mask_q, mask_d;
    logic [INST_WIDTH-1:0]      inst_q, inst_d;
    logic                       rsp_hold_q, rsp_hold_d;
    logic                       first_req_q, first_req_d;

    logic                       upd_valid_d;
    logic [SPLIT_NUM_WIDTH-1:0] upd_split_num_d;
    logic [ADDR_WIDTH-1:0]      upd_pc_d;
    logic                       upd_stall_d;
    logic                       ic_req_valid_d;
    logic [ADDR_WIDTH-1:0]      ic_req_addr_d;
    logic                       dec_valid_d;
    logic [INST_WIDTH-1:0]      dec_inst_d;
    logic [ADDR_WIDTH-1:0]      dec_pc_d;
    logic [SPLIT_NUM_WIDTH-1:0] dec_split_num_d;
    logic [THREAD_NUM-1:0]      dec_thread_mask_d;

    logic                       rsp_new_c;
    logic                       dec_fire_c;

    // A response is new only the first time it is seen in WAIT; later pulses are ignored
    assign rsp_new_c  = (state_q == S_WAIT) && ic_rsp_valid && !rsp_hold_q;
    assign dec_fire_c = (state_q == S_OUT) && rdy && dec_ready;

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            pc_q            <= '0;
            num_q           <= '0;
            mask_q          <= '0;
            inst_q          <= '0;
            rsp_hold_q      <= 1'b0;
            first_req_q     <= 1'b0;
            upd_valid       <= 1'b0;
            upd_split_num   <= '0;
            upd_pc          <= '0;
            upd_stall       <= 1'b0;
            ic_req_valid    <= 1'b0;
            ic_req_addr     <= '0;
            dec_valid       <= 1'b0;
            dec_inst        <= '0;
            dec_pc          <= '0;
            dec_split_num   <= '0;
            dec_thread_mask <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            num_q           <= num_d;
            mask_q          <= mask_d;
            inst_q          <= inst_d;
            rsp_hold_q      <= rsp_hold_d;
            first_req_q     <= first_req_d;
            upd_valid       <= upd_valid_d;
            upd_split_num   <= upd_split_num_d;
            upd_pc          <= upd_pc_d;
            upd_stall       <= upd_stall_d;
            ic_req_valid    <= ic_req_valid_d;
            ic_req_addr     <= ic_req_addr_d;
            dec_valid       <= dec_valid_d;
            dec_inst        <= dec_inst_d;
            dec_pc          <= dec_pc_d;
            dec_split_num   <= dec_split_num_d;
            dec_thread_mask <= dec_thread_mask_d;
        end
    end

    // Next-state and next-output logic; everything holds unless rdy allows a step
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        num_d             = num_q;
        mask_d            = mask_q;
        inst_d            = inst_q;
        rsp_hold_d        = rsp_hold_q;
        first_req_d       = first_req_q;
        upd_valid_d       = 1'b0;
        upd_split_num_d   = upd_split_num;
        upd_pc_d          = upd_pc;
        upd_stall_d       = upd_stall;
        ic_req_valid_d    = ic_req_valid;
        ic_req_addr_d     = ic_req_addr;
        dec_valid_d       = dec_valid;
        dec_inst_d        = dec_inst;
        dec_pc_d          = dec_pc;
        dec_split_num_d   = dec_split_num;
        dec_thread_mask_d = dec_thread_mask;

        case (state_q)
            S_IDLE: begin
                if (rdy && sel_valid) begin
                    pc_d            = sel_pc;
                    num_d           = sel_split_num;
                    first_req_d     = 1'b1;
                    upd_valid_d     = 1'b1;
                    upd_stall_d     = 1'b1;
                    upd_pc_d        = sel_pc;
                    upd_split_num_d = sel_split_num;
                    ic_req_valid_d  = 1'b1;
                    ic_req_addr_d   = sel_pc;
                    state_d         = S_REQ;
                end
            end
            S_REQ: begin
                if (rdy) begin
                    // Table mask for num_q is valid one cycle after the stall update
                    if (first_req_q) begin
                        mask_d      = upd_thread_mask;
                        first_req_d = 1'b0;
                    end
                    if (ic_req_ready) begin
                        ic_req_valid_d = 1'b0;
                        rsp_hold_d     = 1'b0;
                        state_d        = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Response capture is independent of rdy so that none is lost
                if (rsp_new_c) begin
                    inst_d     = ic_rsp_inst;
                    rsp_hold_d = 1'b1;
                end
                if (rdy && (ic_rsp_valid || rsp_hold_q)) begin
                    rsp_hold_d        = 1'b0;
                    dec_valid_d       = 1'b1;
                    dec_inst_d        = rsp_new_c ? ic_rsp_inst : inst_q;
                    dec_pc_d          = pc_q;
                    dec_split_num_d   = num_q;
                    dec_thread_mask_d = mask_q;
                    state_d           = S_OUT;
                end
            end
            S_OUT: begin
                if (dec_fire_c) begin
                    dec_valid_d = 1'b0;
                    upd_valid_d = 1'b1;
                    upd_stall_d = 1'b0;
                    upd_pc_d    = pc_q + ADDR_WIDTH'(PC_STEP);
                    state_d     = S_COOL;
                end
            end
            S_COOL: begin
                if (rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef GELATO_FETCH_PERF_EN
    logic wait_tick_c;

    assign wait_tick_c = rdy && ((state_q == S_REQ) || (state_q == S_WAIT));

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            if (dec_fire_c && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + PERF_WIDTH'(1);
            end
            if (wait_tick_c && (perf_wait_cnt != '1)) begin
                perf_wait_cnt <= perf_wait_cnt + PERF_WIDTH'(1);
            end
        end
    end
`endif

endmodule
